muldiv_unit: RTL

Sequential signed multiply/divide responder for the multi-cycle CPU. It sits on the far end of the control unit's start/done handshake and takes operands straight from the A and B registers. It runs a 32-iteration shift-add multiply or restoring divide, then presents HI/LO with a one-cycle done pulse for the HI/LO register write states. Divide-by-zero is flagged so the controller can raise its exception.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_sign_fix.sv | 34 +++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_pkg;

    localparam int DefWidth = 32;
    localparam int CntWidth = $clog2(DefWidth);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } stateT;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitudes at accept and signed correction of raw results at FIX.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             isDiv,
    input  logic             negRes,
    input  logic             negRem,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] absA,
    output logic [WIDTH-1:0] absB,
    output logic [WIDTH-1:0] fixHi,
    output logic [WIDTH-1:0] fixLo
);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix;
    logic [WIDTH-1:0]   remFix;

    assign absA = a[WIDTH-1] ? -a : a;
    assign absB = b[WIDTH-1] ? -b : b;

    assign prod    = {acc, quo};
    assign prodFix = negRes ? -prod : prod;
    assign quoFix  = negRes ? -quo : quo;
    assign remFix  = negRem ? -acc : acc;

    assign fixHi = isDiv ? remFix : prodFix[2*WIDTH-1:WIDTH];
    assign fixLo = isDiv ? quoFix : prodFix[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Sequential signed shift-add multiply / restoring divide responder.
// MULDIV_ZERO_SKIP_EN: multiply with a zero operand jumps straight to FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DefWidth
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CntW =
        ($clog2(WIDTH) > CntWidth) ? $clog2(WIDTH) : CntWidth;

    stateT            state;
    logic [CntW-1:0]  count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] mag;
    logic             isDiv;
    logic             negRes;
    logic             negRem;
    logic             zeroDiv;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] fixHi;
    logic [WIDTH-1:0] fixLo;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             skipZero;

`ifdef MULDIV_ZERO_SKIP_EN
    assign skipZero = (a == '0) || (b == '0);
`else
    assign skipZero = 1'b0;
`endif

    // acc holds the running high half / partial remainder; quo shifts
    // out multiplier bits or shifts in quotient bits.
    assign mulSum  = {1'b0, acc} + (quo[0] ? {1'b0, mag} : '0);
    assign shifted = {acc, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, mag};

    muldiv_sign_fix #(.WIDTH(WIDTH)) signFix (
        .a      (a),
        .b      (b),
        .isDiv  (isDiv),
        .negRes (negRes),
        .negRem (negRem),
        .acc    (acc),
        .quo    (quo),
        .absA   (absA),
        .absB   (absB),
        .fixHi  (fixHi),
        .fixLo  (fixLo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            quo         <= '0;
            mag         <= '0;
            isDiv       <= 1'b0;
            negRes      <= 1'b0;
            negRem      <= 1'b0;
            zeroDiv     <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    acc     <= '0;
                    count   <= CntW'(WIDTH - 1);
                    negRes  <= a[WIDTH-1] ^ b[WIDTH-1];
                    negRem  <= a[WIDTH-1];
                    zeroDiv <= 1'b0;
                    if (mult_start) begin
                        state <= skipZero ? FIX : MULT;
                        busy  <= 1'b1;
                        isDiv <= 1'b0;
                        mag   <= absA;
                        quo   <= skipZero ? '0 : absB;
                    end else if (div_start) begin
                        busy  <= 1'b1;
                        isDiv <= 1'b1;
                        mag   <= absB;
                        quo   <= absA;
                        if (b == '0) begin
                            state   <= DONE;
                            zeroDiv <= 1'b1;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc <= mulSum[WIDTH:1];
                    quo <= {mulSum[0], quo[WIDTH-1:1]};
                    if (count == '0) state <= FIX;
                    else count <= count - 1'b1;
                end
                DIV: begin
                    if (trial[WIDTH]) begin
                        acc <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end
                    if (count == '0) state <= FIX;
                    else count <= count - 1'b1;
                end
                FIX: begin
                    hi    <= fixHi;
                    lo    <= fixLo;
                    state <= DONE;
                end
                DONE: begin
                    // first DONE cycle raises the pulse, second retires it
                    if (!done) begin
                        done        <= 1'b1;
                        div_by_zero <= zeroDiv;
                    end else begin
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
